// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU) with MTHI/MTLO writes
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, op[1:0]        request an operation in IDLE; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data, rt_data      operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   hi_we, lo_we, wdata   MTHI/MTLO writes, honoured only in IDLE
//   hi, lo                architectural HI/LO registers
//   busy                  operation in progress
//   done                  one-cycle pulse in the cycle after HI/LO commit
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    m;
    logic [2*W-1:0]  acc, acc_nx, prod;
    logic            is_div, neg_q, neg_r;
    logic            accept, commit, sgn, ge;
    logic [W:0]      sum, shifted;
    logic [W-1:0]    a_mag, b_mag, diff, quo, rem;

    assign accept = state == IDLE && start;
    assign commit = state == RUN && cnt == CW'(W - 1);

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb
        state_nx = accept ? RUN : commit ? IDLE : state;

    always_comb
        busy = state == RUN;

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for
    // divide; m holds the multiplicand or the divisor magnitude.
    always_comb begin
        sgn     = ~op[0];
        a_mag   = (sgn && rs_data[W-1]) ? -rs_data : rs_data;
        b_mag   = (sgn && rt_data[W-1]) ? -rt_data : rt_data;
        sum     = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? m : {W{1'b0}}};
        shifted = acc[2*W-1:W-1];
        ge      = shifted >= {1'b0, m};
        // when ge holds the true difference is below 2^W, so the low W bits are exact
        diff    = shifted[W-1:0] - m;
        acc_nx  = is_div ? {ge ? diff : shifted[W-1:0], acc[W-2:0], ge} : {sum, acc[W-1:1]};
        prod    = neg_q ? -acc_nx : acc_nx;
        quo     = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
        rem     = neg_r ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                is_div <= op[1];
                neg_q  <= sgn & (rs_data[W-1] ^ rt_data[W-1]);
                neg_r  <= sgn & rs_data[W-1];
                m      <= op[1] ? b_mag : a_mag;
                acc    <= {{W{1'b0}}, op[1] ? a_mag : b_mag};
                cnt    <= '0;
            end else if (busy) begin
                acc <= acc_nx;
                cnt <= cnt + CW'(1);
            end
            if (state == IDLE && hi_we)
                hi <= wdata;
            if (state == IDLE && lo_we)
                lo <= wdata;
            // a zero divisor leaves the dividend magnitude in the remainder, which the remainder
            // sign turns back into the raw rs_data; only the quotient needs forcing
            if (commit) begin
                hi <= is_div ? rem : prod[2*W-1:W];
                lo <= is_div ? (m == '0 ? {W{1'b1}} : quo) : prod[W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we, busy, done;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata, hi, lo;
    logic [31:0] model_hi, model_lo;
    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r;
        sa  = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
        sbv = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
        if (!o[1])
            return sa * sbv;
        if (b == 0)
            return {a, 32'hFFFFFFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0)
                check("done_unexp", {63'b0, done}, 64'd0);
            else
                check("hilo", {hi, lo}, sb.pop_front());
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit mt, input bit disturb);
        int n, nb;
        sb.push_back(exp);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        if (mt) begin
            hi_we = 1'b1;
            wdata = 32'hCAFEF00D;
        end
        tick();
        start = 1'b0; hi_we = 1'b0;
        if (mt)
            check("mt_at_start", {32'b0, hi}, {32'b0, 32'hCAFEF00D});
        n = 0;
        nb = 0;
        while (!done && n < 40) begin
            if (busy)
                nb++;
            if (disturb) begin
                start = 1'b1; op = 2'b00; rs_data = 32'h11111111; rt_data = 32'h3;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA55AA;
            end
            if (disturb && n == 16)
                check("hold_run", {hi, lo}, {model_hi, model_lo});
            tick();
            n++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("latency", 64'(n), 64'd32);
        check("busy_cycles", 64'(nb), 64'd32);
        {model_hi, model_lo} = exp;
        tick();
        check("done_pulse", {63'b0, done}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; rs_data = '0; rt_data = '0; wdata = '0;
        repeat (2) tick();
        reset = 1'b0;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'b0, busy, done}, 64'd0);
        model_hi = '0;
        model_lo = '0;

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, 0);
        do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 0, 0);
        do_op(2'b11, 32'd7, 32'd2, 64'h00000001_00000003, 0, 0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0, 0);
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0, 0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, 0);
        do_op(2'b10, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF, 0, 0);
        do_op(2'b11, 32'h87654321, 32'h0, 64'h87654321_FFFFFFFF, 0, 0);
        do_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 0, 0);

        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        tick();
        hi_we = 1'b0;
        check("mthi", {hi, lo}, {32'hDEADBEEF, model_lo});
        model_hi = 32'hDEADBEEF;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'h0BADF00D, 32'h0BADF00D});
        model_hi = 32'h0BADF00D;
        model_lo = 32'h0BADF00D;

        do_op(2'b11, 32'd7, 32'd2, 64'h00000001_00000003, 0, 1);
        do_op(2'b01, 32'd3, 32'd4, 64'h00000000_0000000C, 1, 0);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 5) ? 32'h0 : $urandom >> $urandom_range(0, 28);
            do_op(o, a, b, model(o, a, b), 0, 0);
        end

        op = 2'b01; rs_data = 32'd5; rt_data = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy_done", {62'b0, busy, done}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        repeat (40) tick();
        check("abort_idle", {63'b0, busy}, 64'd0);
        do_op(2'b01, 32'd5, 32'd6, 64'h00000000_0000001E, 0, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
